// File: rtl/apb_master_ctrl.sv
// APB master stage: runs one SETUP/ACCESS sequence per accepted bridge request.
// Latency: accept at edge N, SETUP N+1, ACCESS N+2, rsp_valid N+3 plus one cycle per wait state.
// Backpressure: req_ready only in IDLE; requests offered while busy are left with the upstream side.
module apb_master_ctrl #(
    parameter int DSIZE   = 32,
    parameter int ASIZE   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             Pclk,
    input  logic             Preset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [ASIZE-1:0] req_addr,
    input  logic [DSIZE-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [DSIZE-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             Psel,
    output logic             Penable,
    output logic             Pwrite,
    output logic [ASIZE-1:0] Paddr,
    output logic [DSIZE-1:0] Pwdata,
    input  logic [DSIZE-1:0] Prdata,
    input  logic             Pready,
    input  logic             Pslverr
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLIM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] tcnt;
    logic          timeout_hit;

    // A zero TIMEOUT leaves the slave free to stall indefinitely.
    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT != 0)
            timeout_hit = !Pready && (tcnt == TLIM);
    end

    assign Psel      = (state == SETUP) || (state == ACCESS);
    assign Penable   = (state == ACCESS);
    assign req_ready = (state == IDLE) && !Preset;

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state     <= IDLE;
            tcnt      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        Pwrite <= req_write;
                        Paddr  <= req_addr;
                        Pwdata <= req_wdata;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    tcnt  <= '0;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (Pready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= Pslverr;
                        rsp_rdata <= Pwrite ? '0 : Prdata;
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else if (tcnt != '1) begin
                        // saturate rather than wrap when the timeout is disabled
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with TIMEOUT=4; inputs change and outputs are
// sampled 1ns after each rising edge.
module tb_apb_master_ctrl;

    logic        Pclk = 1'b0;
    logic        Preset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    int vectors     = 0;
    int miscompares = 0;

    apb_master_ctrl #(.DSIZE(32), .ASIZE(32), .TIMEOUT(4)) dut (
        .Pclk      (Pclk),
        .Preset    (Preset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .Psel      (Psel),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .Pready    (Pready),
        .Pslverr   (Pslverr)
    );

    always #5 Pclk = ~Pclk;

    task automatic tick();
        @(posedge Pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        Prdata = '0; Pready = 1'b0; Pslverr = 1'b0;
        tick();
        tick();
        chk("rst_psel",    32'(Psel), 32'd0);
        chk("rst_penable", 32'(Penable), 32'd0);
        chk("rst_rsp_vld", 32'(rsp_valid), 32'd0);
        chk("rst_rdy",     32'(req_ready), 32'd0);
        chk("rst_paddr",   Paddr, 32'd0);
        Preset = 1'b0;
        tick();
        chk("idle_rdy", 32'(req_ready), 32'd1);

        // write, no wait states
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'hDEADBEEF;
        Pready = 1'b1; Prdata = 32'h12345678;
        tick();
        req_valid = 1'b0;
        chk("wr_setup_psel", 32'(Psel), 32'd1);
        chk("wr_setup_pen",  32'(Penable), 32'd0);
        chk("wr_setup_rdy",  32'(req_ready), 32'd0);
        chk("wr_paddr",      Paddr, 32'h4);
        chk("wr_pwdata",     Pwdata, 32'hDEADBEEF);
        tick();
        chk("wr_acc_pen",    32'(Penable), 32'd1);
        chk("wr_acc_pwrite", 32'(Pwrite), 32'd1);
        chk("wr_acc_rvld",   32'(rsp_valid), 32'd0);
        tick();
        chk("wr_rsp_vld",   32'(rsp_valid), 32'd1);
        chk("wr_rsp_err",   32'(rsp_err), 32'd0);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);
        chk("wr_idle_psel", 32'(Psel), 32'd0);
        chk("wr_idle_rdy",  32'(req_ready), 32'd1);
        tick();
        chk("wr_rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("wr_paddr_hold", Paddr, 32'h4);

        // read with two wait states
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4; Pready = 1'b0; Prdata = '0;
        tick();
        req_valid = 1'b0;
        chk("rd_setup_pwrite", 32'(Pwrite), 32'd0);
        tick();
        chk("rd_acc1_pen", 32'(Penable), 32'd1);
        tick();
        chk("rd_acc2_pen", 32'(Penable), 32'd1);
        chk("rd_acc2_rvld", 32'(rsp_valid), 32'd0);
        tick();
        chk("rd_acc3_pen", 32'(Penable), 32'd1);
        Pready = 1'b1; Prdata = 32'hDEADBEEF;
        tick();
        chk("rd_rsp_vld",   32'(rsp_valid), 32'd1);
        chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd_rsp_err",   32'(rsp_err), 32'd0);
        Pready = 1'b0; Prdata = 32'h0;
        tick();
        chk("rd_rdata_hold", rsp_rdata, 32'hDEADBEEF);
        chk("rd_rsp_pulse",  32'(rsp_valid), 32'd0);

        // slave error
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8; Pready = 1'b1; Pslverr = 1'b1;
        Prdata = 32'h55;
        tick();
        req_valid = 1'b0;
        chk("se_paddr", Paddr, 32'h8);
        tick();
        tick();
        chk("se_rsp_vld",   32'(rsp_valid), 32'd1);
        chk("se_rsp_err",   32'(rsp_err), 32'd1);
        chk("se_rsp_rdata", rsp_rdata, 32'h55);
        Pslverr = 1'b0;

        // timeout after exactly four ACCESS cycles
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hC; Pready = 1'b0; Prdata = 32'hFFFFFFFF;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("to_acc%0d_pen", i), 32'(Penable), 32'd1);
            chk($sformatf("to_acc%0d_rvld", i), 32'(rsp_valid), 32'd0);
        end
        tick();
        chk("to_rsp_vld",   32'(rsp_valid), 32'd1);
        chk("to_rsp_err",   32'(rsp_err), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'd0);
        chk("to_idle_psel", 32'(Psel), 32'd0);
        chk("to_idle_rdy",  32'(req_ready), 32'd1);
        tick();

        // back-to-back writes with req_valid held high
        Pready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1; req_wdata = 32'hA1;
        chk("b2b_psel0", 32'(Psel), 32'd0);
        tick();
        chk("b2b_psel1", 32'(Psel), 32'd1);
        chk("b2b_paddr1", Paddr, 32'h1);
        req_addr = 32'h2; req_wdata = 32'hA2;
        tick();
        chk("b2b_psel2", 32'(Psel), 32'd1);
        tick();
        chk("b2b_psel3", 32'(Psel), 32'd0);
        chk("b2b_rvld1", 32'(rsp_valid), 32'd1);
        chk("b2b_rdy3",  32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("b2b_psel4", 32'(Psel), 32'd1);
        chk("b2b_paddr2", Paddr, 32'h2);
        chk("b2b_pwdata2", Pwdata, 32'hA2);
        tick();
        chk("b2b_psel5", 32'(Psel), 32'd1);
        tick();
        chk("b2b_rvld2", 32'(rsp_valid), 32'd1);

        // reset while stalled in ACCESS
        Pready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mr_acc_pen", 32'(Penable), 32'd1);
        Preset = 1'b1;
        tick();
        chk("mr_psel",  32'(Psel), 32'd0);
        chk("mr_pen",   32'(Penable), 32'd0);
        chk("mr_rvld",  32'(rsp_valid), 32'd0);
        Preset = 1'b0;
        tick();
        chk("mr_rdy",   32'(req_ready), 32'd1);
        chk("mr_rvld2", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
